// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, data width and line idle level.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } uart_state_e;
`endif

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, with a parameterised reset value.
module bit_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, LSB first, mid-bit sampling from a synchronized line.
// Define UART_RX_PARITY_EN to compile in the even-parity bit and its check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  logic rx_s;

  bit_sync #(
    .ResetVal(IDLE_LEVEL)
  ) u_bit_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic dv_q, dv_d;
  logic ferr_q, ferr_d;

`ifdef UART_RX_PARITY_EN
  logic par_pend_q, par_pend_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_pend_d = par_pend_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_s != IDLE_LEVEL) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A high line at mid-start is treated as a glitch and dropped silently.
          state_d = (rx_s == IDLE_LEVEL) ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
          par_pend_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d      = '0;
          par_pend_d = (rx_s != ^shreg_q);
          state_d    = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rx_s == IDLE_LEVEL) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_pend_q) begin
              perr_d = 1'b1;
            end else begin
              data_d = shreg_q;
              dv_d   = 1'b1;
            end
`else
            data_d = shreg_q;
            dv_d   = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (rx_s == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_pend_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      par_pend_q <= par_pend_d;
      perr_q     <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; covers parity cases when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int Latency = 3 + 19 * C / 2 + (FrameBits - 10) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cycles[$];
  int dv_vals[$];
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int excl_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled half a cycle after the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cycles.push_back(cyc);
      dv_vals.push_back(int'(data_out));
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    dv_cycles.delete();
    dv_vals.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_ok);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ ~par_ok);
`else
    if (!par_ok) $display("note: parity request ignored without parity build");
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    int first_start;
    repeat (5) @(negedge clk);
    check_eq("rst_data_out", int'(data_out), 0);
    check_eq("rst_data_valid", int'(data_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_frame_err", int'(frame_err), 0);
    check_eq("rst_parity_err", int'(parity_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte 0xA5, fixed latency.
    clear_mon();
    send_byte(8'hA5, 1'b1, 1'b1);
    check_eq("a5_dv_count", dv_cycles.size(), 1);
    if (dv_cycles.size() == 1) begin
      check_eq("a5_value", dv_vals[0], 'hA5);
      check_eq("a5_latency", dv_cycles[0] - start_cyc, Latency);
    end
    check_eq("a5_data_out", int'(data_out), 'hA5);
    check_eq("a5_ferr", ferr_cnt, 0);
    check_eq("a5_perr", perr_cnt, 0);
    check_eq("a5_busy", int'(busy), 0);
    repeat (2 * C) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    clear_mon();
    send_byte(8'h00, 1'b1, 1'b1);
    first_start = start_cyc;
    send_byte(8'hFF, 1'b1, 1'b1);
    check_eq("b2b_dv_count", dv_cycles.size(), 2);
    if (dv_cycles.size() == 2) begin
      check_eq("b2b_first_lat", dv_cycles[0] - first_start, Latency);
      check_eq("b2b_spacing", dv_cycles[1] - dv_cycles[0], FrameBits * C);
      check_eq("b2b_val0", dv_vals[0], 'h00);
      check_eq("b2b_val1", dv_vals[1], 'hFF);
    end
    check_eq("b2b_ferr", ferr_cnt, 0);
    repeat (2 * C) @(negedge clk);

    // Short low glitch must be rejected at mid-start.
    clear_mon();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("glitch_busy_high", int'(busy), 1);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check_eq("glitch_busy_low", int'(busy), 0);
    check_eq("glitch_pulses", dv_cycles.size() + ferr_cnt + perr_cnt, 0);
    send_byte(8'h3C, 1'b1, 1'b1);
    check_eq("3c_dv_count", dv_cycles.size(), 1);
    check_eq("3c_data_out", int'(data_out), 'h3C);
    repeat (2 * C) @(negedge clk);

    // Bad stop bit followed by a long break.
    clear_mon();
    send_byte(8'h55, 1'b0, 1'b1);
    repeat (50 * C) @(negedge clk);
    check_eq("brk_ferr_count", ferr_cnt, 1);
    check_eq("brk_dv_count", dv_cycles.size(), 0);
    check_eq("brk_data_out", int'(data_out), 'h3C);
    check_eq("brk_busy_held", int'(busy), 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("brk_busy_released", int'(busy), 0);
    check_eq("brk_ferr_final", ferr_cnt, 1);
    repeat (2 * C) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    clear_mon();
    send_byte(8'h07, 1'b1, 1'b0);
    check_eq("par_bad_perr", perr_cnt, 1);
    check_eq("par_bad_dv", dv_cycles.size(), 0);
    check_eq("par_bad_data_out", int'(data_out), 'h3C);
    repeat (2 * C) @(negedge clk);
    clear_mon();
    send_byte(8'h07, 1'b1, 1'b1);
    check_eq("par_ok_perr", perr_cnt, 0);
    check_eq("par_ok_dv", dv_cycles.size(), 1);
    check_eq("par_ok_data_out", int'(data_out), 'h07);
    repeat (2 * C) @(negedge clk);
`else
    check_eq("noparity_perr_total", perr_cnt, 0);
`endif

    // Reset in the middle of data bit 4 of 0x81.
    clear_mon();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_data_out", int'(data_out), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_dv", int'(data_valid), 0);
    rst = 1'b0;
    repeat (3 * C) @(negedge clk);
    check_eq("mid_rst_pulses", dv_cycles.size() + ferr_cnt + perr_cnt, 0);
    send_byte(8'h42, 1'b1, 1'b1);
    check_eq("42_dv_count", dv_cycles.size(), 1);
    check_eq("42_data_out", int'(data_out), 'h42);
    if (dv_cycles.size() == 1) check_eq("42_latency", dv_cycles[0] - start_cyc, Latency);
    repeat (C) @(negedge clk);

    check_eq("pulse_exclusive", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
